puf_eval_ctrl: RTL and testbench
================================

PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 SHALL have parameter WINDOW, default 1024, counting-window length in clk cycles (>=2).
REQ-002 SHALL have parameter SETTLE_CYC, default 4, oscillator settle cycles before counting (>=3).
REQ-003 SHALL have parameter CNT_W, default 16, edge-counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 ena  in  1  global enable; low freezes all state.
REQ-007 start  in  1  request an 8-bit evaluation; sampled in IDLE only.
REQ-008 challenge  in  5  base challenge; captured on accepted start.
REQ-009 ro_a, ro_b  in  1 each  raw ring-oscillator outputs, asynchronous to clk.
REQ-010 sel_a, sel_b  out  5 each  ring-oscillator select for the current pair.
REQ-011 ro_en  out  1  oscillator enable.
REQ-012 response  out  8  evaluated response word.
REQ-013 valid  out  1  one-cycle pulse: response updated.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, SETTLE, COUNT, COMPARE, DONE.
REQ-016 IDLE->SETTLE when start=1 and ena=1; captures challenge, bit index i=0; start in any other state ignored.
REQ-017 SETTLE: ro_en=1, both counters cleared, lasts exactly SETTLE_CYC cycles, then COUNT.
REQ-018 COUNT: ro_en=1, lasts exactly WINDOW cycles; each counter increments once per synchronized rising edge of its oscillator.
REQ-019 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-020 COMPARE (1 cycle, ro_en=0): response[i] <= (cnt_a > cnt_b); tie yields 0; then i<7 -> SETTLE with i+1, i=7 -> DONE.
REQ-021 Pair mapping: sel_a = challenge_q + i, sel_b = challenge_q + i + 16, both modulo 32 (5-bit wrap); stable throughout SETTLE/COUNT/COMPARE of bit i.
REQ-022 DONE (1 cycle): valid=1, then IDLE; response holds until next DONE overwrites it.
REQ-023 Latency: valid asserted on the 8*(SETTLE_CYC+WINDOW+1)+1-th rising edge after the edge accepting start (with ena=1 throughout).
REQ-024 ena=0: state, counters, index, outputs frozen; oscillator edges ignored; resumes unchanged when ena returns high.
REQ-025 response bits written only in COMPARE; partial results from an interrupted run are never flagged valid.
REQ-026 sel_a/sel_b SHALL read 0 in IDLE.

Reset
REQ-027 rst_n low: state=IDLE, i=0, counters=0, synchronizers=0, challenge_q=0, response=0, valid=0, busy=0, ro_en=0, sel_a=sel_b=0.
REQ-028 Reset asserted mid-run aborts immediately; no valid pulse follows deassertion.

Structure
REQ-029 Package puf_pkg SHALL hold the state enum, NUM_BITS=8, CHAL_W=5, PAIR_OFFSET=16.
REQ-030 Sub-module puf_edge_counter SHALL contain 2-flop synchronizer, rising-edge detect, clear, count-enable, saturating CNT_W counter; instantiated twice (A, B).
REQ-031 Synchronizer flops SHALL be reset by rst_n; no combinational path from ro_a/ro_b to any output.

Verification (WINDOW=16, SETTLE_CYC=4, CNT_W=4 unless stated)
REQ-032 ro_a period 4 clk, ro_b period 8 clk, challenge=0, start pulse -> valid on edge 169 after start, response=0xFF, busy low afterwards.
REQ-033 ro_a period 8, ro_b period 4 -> response=0x00; equal periods, same phase -> ties -> response=0x00.
REQ-034 challenge=30 -> observed (sel_a,sel_b) sequence (30,14),(31,15),(0,16),(1,17)...(5,21).
REQ-035 ro_a toggling every cycle with CNT_W=3 -> cnt_a saturates at 7, no wrap; ro_b period 8 -> response=0xFF.
REQ-036 start re-pulsed during COUNT -> ignored, single valid; ena low 50 cycles mid-COUNT -> valid delayed exactly 50 cycles, response unchanged.
REQ-037 rst_n low during bit 3 COUNT -> all outputs at reset values immediately, no valid; fresh start completes normally.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF evaluation controller.
package puf_pkg;

  localparam int NUM_BITS    = 8;
  localparam int CHAL_W      = 5;
  localparam int PAIR_OFFSET = 16;
  localparam int IDX_W       = $clog2(NUM_BITS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    COMPARE,
    DONE
  } puf_state_e;

  // Oscillator select for bit idx: base + idx + offset, wrapping in CHAL_W bits.
  function automatic logic [CHAL_W-1:0] pair_sel(
    input logic [CHAL_W-1:0] base,
    input logic [IDX_W-1:0]  idx,
    input logic [CHAL_W-1:0] offset
  );
    return base + CHAL_W'(idx) + offset;
  endfunction

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Request/response bus of the PUF evaluation controller.
interface puf_eval_ctrl_if;
  import puf_pkg::*;

  logic                start;
  logic [CHAL_W-1:0]   challenge;
  logic [NUM_BITS-1:0] response;
  logic                valid;
  logic                busy;

  modport master (
    output start,
    output challenge,
    input  response,
    input  valid,
    input  busy
  );

  modport slave (
    input  start,
    input  challenge,
    output response,
    output valid,
    output busy
  );

endinterface

// File: rtl/puf_edge_counter.sv
// Synchronizes one raw oscillator into clk, detects its rising edges and
// counts them in a saturating counter with synchronous clear and enable.
module puf_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             ro_in,
  input  logic             clr,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sync1;
  logic sync2;
  logic prev;
  logic rise;

  // Two-flop synchronizer plus one history flop for edge detection; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else if (ena) begin
      sync1 <= ro_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  // Saturating edge counter: stops at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ena) begin
      if (clr) begin
        cnt <= '0;
      end else if (cnt_en && rise && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Ring-oscillator PUF evaluation controller: for each of 8 response bits it
// selects an oscillator pair, lets it settle, counts edges of both over a
// fixed window and records which oscillator ran faster.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int WINDOW     = 1024,
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  puf_eval_ctrl_if.slave     bus,
  input  logic               ro_a,
  input  logic               ro_b,
  output logic [CHAL_W-1:0]  sel_a,
  output logic [CHAL_W-1:0]  sel_b,
  output logic               ro_en
);

  // The phase timer is shared by SETTLE and COUNT, so size it for the longer one.
  localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);

  puf_state_e          state,       state_d;
  logic [IDX_W-1:0]    idx,         idx_d;
  logic [TMR_W-1:0]    tmr,         tmr_d;
  logic [CHAL_W-1:0]   challenge_q, challenge_d;
  logic [NUM_BITS-1:0] res_work,    res_work_d;
  logic [NUM_BITS-1:0] response_q,  response_d;
  logic                valid_q,     valid_d;
  logic                cnt_clr;
  logic                cnt_en;
  logic [CNT_W-1:0]    cnt_a;
  logic [CNT_W-1:0]    cnt_b;

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ro_in  (ro_a),
    .clr    (cnt_clr),
    .cnt_en (cnt_en),
    .cnt    (cnt_a)
  );

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ro_in  (ro_b),
    .clr    (cnt_clr),
    .cnt_en (cnt_en),
    .cnt    (cnt_b)
  );

  // Controller registers; everything holds its value while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      tmr         <= '0;
      challenge_q <= '0;
      res_work    <= '0;
      response_q  <= '0;
      valid_q     <= 1'b0;
    end else if (ena) begin
      state       <= state_d;
      idx         <= idx_d;
      tmr         <= tmr_d;
      challenge_q <= challenge_d;
      res_work    <= res_work_d;
      response_q  <= response_d;
      valid_q     <= valid_d;
    end
  end

  // Next-state logic: bits are built up in res_work and only published in DONE,
  // so an aborted run never exposes a partial word.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    tmr_d       = tmr;
    challenge_d = challenge_q;
    res_work_d  = res_work;
    response_d  = response_q;
    valid_d     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d     = SETTLE;
          challenge_d = bus.challenge;
          idx_d       = '0;
          tmr_d       = '0;
        end
      end

      SETTLE: begin
        cnt_clr = 1'b1;
        if (tmr == SETTLE_LAST) begin
          tmr_d   = '0;
          state_d = COUNT;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end

      COUNT: begin
        cnt_en = 1'b1;
        if (tmr == WINDOW_LAST) begin
          tmr_d   = '0;
          state_d = COMPARE;
        end else begin
          tmr_d = tmr + 1'b1;
        end
      end

      COMPARE: begin
        res_work_d[idx] = (cnt_a > cnt_b);
        if (idx == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx + 1'b1;
          state_d = SETTLE;
        end
      end

      DONE: begin
        response_d = res_work;
        valid_d    = 1'b1;
        idx_d      = '0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Oscillator pair select follows the current bit; parked at zero when idle.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    if (state != IDLE) begin
      sel_a = pair_sel(challenge_q, idx, '0);
      sel_b = pair_sel(challenge_q, idx, CHAL_W'(PAIR_OFFSET));
    end
  end

  assign ro_en        = (state == SETTLE) || (state == COUNT);
  assign bus.busy     = (state != IDLE);
  assign bus.response = response_q;
  assign bus.valid    = valid_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed, self-checking bench for puf_eval_ctrl with a response scoreboard.
module tb_puf_eval_ctrl;

  localparam int WINDOW     = 16;
  localparam int SETTLE_CYC = 4;
  localparam int LAT        = 8 * (SETTLE_CYC + WINDOW + 1) + 1;
  localparam int BIT_CYC    = SETTLE_CYC + WINDOW + 1;

  logic clk;
  logic rst_n;
  logic ena;
  logic ro_a_osc;
  logic ro_b_osc;
  logic ro_fast;
  logic ro_b_main;
  logic tie_mode;
  int   half_a;
  int   half_b;

  logic [4:0] sel_a,  sel_b;
  logic [4:0] sel_a3, sel_b3;
  logic       ro_en,  ro_en3;

  int checks;
  int failures;

  logic [7:0] exp_q[$];
  logic [7:0] exp3_q[$];

  puf_eval_ctrl_if bus();
  puf_eval_ctrl_if bus3();

  assign ro_b_main = tie_mode ? ro_a_osc : ro_b_osc;

  puf_eval_ctrl #(.WINDOW(WINDOW), .SETTLE_CYC(SETTLE_CYC), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus),
    .ro_a  (ro_a_osc),
    .ro_b  (ro_b_main),
    .sel_a (sel_a),
    .sel_b (sel_b),
    .ro_en (ro_en)
  );

  puf_eval_ctrl #(.WINDOW(WINDOW), .SETTLE_CYC(SETTLE_CYC), .CNT_W(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus3),
    .ro_a  (ro_fast),
    .ro_b  (ro_b_osc),
    .sel_a (sel_a3),
    .sel_b (sel_b3),
    .ro_en (ro_en3)
  );

  // Clock: period 10; oscillators toggle on multiples of 10, away from the rising edges at 5+10k.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ro_a_osc = 1'b0;
    forever #(half_a) ro_a_osc = ~ro_a_osc;
  end

  initial begin
    ro_b_osc = 1'b0;
    forever #(half_b) ro_b_osc = ~ro_b_osc;
  end

  initial begin
    ro_fast = 1'b0;
    forever #10 ro_fast = ~ro_fast;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one cycle on the chosen DUT and records the expected response.
  task automatic applyStimulus(input int which, input logic [4:0] chal, input logic [7:0] exp_resp);
    @(negedge clk);
    if (which == 0) begin
      bus.start     = 1'b1;
      bus.challenge = chal;
      exp_q.push_back(exp_resp);
    end else begin
      bus3.start     = 1'b1;
      bus3.challenge = chal;
      exp3_q.push_back(exp_resp);
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus3.start = 1'b0;
  endtask

  task automatic waitValid(input int which, input int edges_done, input int exp_edges, input string tag);
    int         edges;
    logic       seen;
    logic [7:0] exp_resp;
    logic [7:0] resp;
    logic       busy_now;
    logic       valid_now;
    edges = edges_done;
    seen  = 1'b0;
    while (!seen && edges < exp_edges + 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = (which == 0) ? bus.valid : bus3.valid;
    end
    checkOutput({tag, "_valid_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, "_latency"}, 32'(edges), 32'(exp_edges));
      resp     = (which == 0) ? bus.response : bus3.response;
      busy_now = (which == 0) ? bus.busy : bus3.busy;
      if (which == 0) begin
        checkOutput({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        exp_resp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      end else begin
        checkOutput({tag, "_sb_nonempty"}, 32'(exp3_q.size() > 0), 32'd1);
        exp_resp = (exp3_q.size() > 0) ? exp3_q.pop_front() : 8'hxx;
      end
      checkOutput({tag, "_response"}, 32'(resp), 32'(exp_resp));
      checkOutput({tag, "_busy_after"}, 32'(busy_now), 32'd0);
      @(negedge clk);
      valid_now = (which == 0) ? bus.valid : bus3.valid;
      checkOutput({tag, "_valid_pulse"}, 32'(valid_now), 32'd0);
    end
  endtask

  task automatic watchNoValid(input int cycles, input string tag);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.valid) cnt++;
    end
    checkOutput(tag, 32'(cnt), 32'd0);
  endtask

  task automatic setPeriods(input int pa, input int pb, input logic tie);
    half_a   = pa * 5;
    half_b   = pb * 5;
    tie_mode = tie;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int         edges;
    logic [4:0] exp_sa;
    logic [4:0] exp_sb;

    checks        = 0;
    failures      = 0;
    half_a        = 20;
    half_b        = 40;
    tie_mode      = 1'b0;
    ena           = 1'b1;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.challenge = '0;
    bus3.start     = 1'b0;
    bus3.challenge = '0;

    #23;
    checkOutput("rst_busy",     32'(bus.busy),     32'd0);
    checkOutput("rst_valid",    32'(bus.valid),    32'd0);
    checkOutput("rst_response", 32'(bus.response), 32'd0);
    checkOutput("rst_ro_en",    32'(ro_en),        32'd0);
    checkOutput("rst_sel_a",    32'(sel_a),        32'd0);
    checkOutput("rst_sel_b",    32'(sel_b),        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] a faster than b");
    setPeriods(4, 8, 1'b0);
    applyStimulus(0, 5'd0, 8'hFF);
    waitValid(0, 0, LAT, "a_fast");

    $display("[TB] b faster than a");
    setPeriods(8, 4, 1'b0);
    applyStimulus(0, 5'd0, 8'h00);
    waitValid(0, 0, LAT, "b_fast");

    $display("[TB] equal oscillators tie");
    setPeriods(4, 4, 1'b1);
    applyStimulus(0, 5'd3, 8'h00);
    waitValid(0, 0, LAT, "tie");

    $display("[TB] pair select sequence from challenge 30");
    setPeriods(4, 8, 1'b0);
    checkOutput("idle_sel_a", 32'(sel_a), 32'd0);
    checkOutput("idle_sel_b", 32'(sel_b), 32'd0);
    applyStimulus(0, 5'd30, 8'hFF);
    edges = 0;
    for (int i = 0; i < 8; i++) begin
      while (edges < i * BIT_CYC + 10) begin
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
      exp_sa = 5'((30 + i) % 32);
      exp_sb = 5'((30 + i + 16) % 32);
      checkOutput($sformatf("sel_a_bit%0d", i), 32'(sel_a), 32'(exp_sa));
      checkOutput($sformatf("sel_b_bit%0d", i), 32'(sel_b), 32'(exp_sb));
      checkOutput($sformatf("ro_en_count_bit%0d", i), 32'(ro_en), 32'd1);
      if (i == 0) begin
        while (edges < SETTLE_CYC + WINDOW) begin
          @(posedge clk);
          edges++;
          @(negedge clk);
        end
        checkOutput("ro_en_compare_bit0", 32'(ro_en), 32'd0);
      end
    end
    waitValid(0, edges, LAT, "chal30");

    $display("[TB] start re-pulsed mid-run");
    applyStimulus(0, 5'd7, 8'hFF);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitValid(0, 10, LAT, "repulse");
    watchNoValid(200, "repulse_single_valid");

    $display("[TB] enable dropped for 50 cycles mid-count");
    applyStimulus(0, 5'd9, 8'hFF);
    repeat (9) @(negedge clk);
    ena = 1'b0;
    repeat (50) @(negedge clk);
    ena = 1'b1;
    waitValid(0, 59, LAT + 50, "freeze");

    $display("[TB] reset during bit 3 count");
    applyStimulus(0, 5'd0, 8'hFF);
    repeat (70) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",     32'(bus.busy),     32'd0);
    checkOutput("midrst_valid",    32'(bus.valid),    32'd0);
    checkOutput("midrst_response", 32'(bus.response), 32'd0);
    checkOutput("midrst_ro_en",    32'(ro_en),        32'd0);
    checkOutput("midrst_sel_a",    32'(sel_a),        32'd0);
    checkOutput("midrst_sel_b",    32'(sel_b),        32'd0);
    exp_q.delete();
    exp3_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    watchNoValid(200, "midrst_no_valid");
    applyStimulus(0, 5'd0, 8'hFF);
    waitValid(0, 0, LAT, "after_rst");

    $display("[TB] 3-bit counter saturation");
    applyStimulus(1, 5'd0, 8'hFF);
    waitValid(1, 0, LAT, "sat3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
